// File: rtl/pipelined_decode_unit.sv
// RV32I decode stage: combinational decode of the fetched word into a control
// bundle, queued in a DEPTH-entry FIFO so fetch and execute stall independently.
module pipelined_decode_unit #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int ENABLE_M   = 0,
  parameter int ENABLE_CSR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rf_wen,
  output logic            out_dm_wen,
  output logic            out_dm_ren,
  output logic [2:0]      out_mem_size,
  output logic [1:0]      out_wdata_sel,
  output logic [1:0]      out_op1_sel,
  output logic            out_op2_sel,
  output logic [4:0]      out_alu_op,
  output logic [XLEN-1:0] out_imm,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic [2:0]      out_branch_cond,
  output logic            out_csr_wen,
  output logic            out_csr_sel,
  output logic [11:0]     out_csr_addr,
  output logic            out_mret,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic            rf_wen, dm_wen, dm_ren;
    logic [2:0]      mem_size;
    logic [1:0]      wdata_sel, op1_sel;
    logic            op2_sel;
    logic [4:0]      alu_op;
    logic [XLEN-1:0] imm;
    logic            branch, jal, jalr;
    logic [2:0]      branch_cond;
    logic            csr_wen, csr_sel;
    logic [11:0]     csr_addr;
    logic            mret, illegal;
  } dec_t;

  localparam logic [6:0] OPC_LUI = 7'h37, OPC_AUIPC = 7'h17, OPC_JAL = 7'h6F,
                         OPC_JALR = 7'h67, OPC_LOAD = 7'h03, OPC_STORE = 7'h23,
                         OPC_BRANCH = 7'h63, OPC_OPIMM = 7'h13, OPC_OP = 7'h33,
                         OPC_FENCE = 7'h0F, OPC_SYSTEM = 7'h73;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                         ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_MUL = 5'd10;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [4:0] alu_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_f3 = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_f3 = ALU_SLL;
      3'd2:    alu_f3 = ALU_SLT;
      3'd3:    alu_f3 = ALU_SLTU;
      3'd4:    alu_f3 = ALU_XOR;
      3'd5:    alu_f3 = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            ill;
  dec_t            dec;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign rd    = in_instr[11:7];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign imm_i = {{(XLEN-11){in_instr[31]}}, in_instr[30:20]};
  assign imm_s = {{(XLEN-11){in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
  assign imm_b = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    dec    = '0;
    ill    = 1'b0;
    dec.pc = in_pc;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        dec.rd      = rd;
        dec.rf_wen  = 1'b1;
        dec.op1_sel = (opc == OPC_LUI) ? 2'd2 : 2'd1;
        dec.op2_sel = 1'b1;
        dec.imm     = imm_u;
      end
      OPC_JAL: begin
        // ALU forms the target PC+imm; rd receives PC+4
        dec.rd        = rd;
        dec.rf_wen    = 1'b1;
        dec.wdata_sel = 2'd2;
        dec.jal       = 1'b1;
        dec.op1_sel   = 2'd1;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_j;
      end
      OPC_JALR: begin
        dec.rs1       = rs1;
        dec.rd        = rd;
        dec.rf_wen    = 1'b1;
        dec.wdata_sel = 2'd2;
        dec.jalr      = 1'b1;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_i;
      end
      OPC_LOAD: begin
        ill           = (f3 == 3'd3) || (f3[2] && f3[1]);
        dec.rs1       = rs1;
        dec.rd        = rd;
        dec.rf_wen    = 1'b1;
        dec.dm_ren    = 1'b1;
        dec.wdata_sel = 2'd1;
        dec.op2_sel   = 1'b1;
        dec.imm       = imm_i;
        dec.mem_size  = f3;
      end
      OPC_STORE: begin
        ill          = (f3 > 3'd2);
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.dm_wen   = 1'b1;
        dec.op2_sel  = 1'b1;
        dec.imm      = imm_s;
        dec.mem_size = f3;
      end
      OPC_BRANCH: begin
        ill             = (f3 == 3'd2) || (f3 == 3'd3);
        dec.rs1         = rs1;
        dec.rs2         = rs2;
        dec.branch      = 1'b1;
        dec.branch_cond = f3;
        dec.imm         = imm_b;
        dec.alu_op      = !f3[2] ? ALU_SUB : (f3[1] ? ALU_SLTU : ALU_SLT);
      end
      OPC_OPIMM: begin
        // shamt occupies instr[24:20]; fn7 bit 5 picks SRAI
        if (f3 == 3'd1)      ill = (f7 != 7'h00);
        else if (f3 == 3'd5) ill = (f7 != 7'h00) && (f7 != 7'h20);
        dec.rs1     = rs1;
        dec.rd      = rd;
        dec.rf_wen  = 1'b1;
        dec.op2_sel = 1'b1;
        dec.imm     = imm_i;
        dec.alu_op  = alu_f3(f3, (f3 == 3'd5) && f7[5]);
      end
      OPC_OP: begin
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.rd     = rd;
        dec.rf_wen = 1'b1;
        if (f7 == 7'h00)                                    dec.alu_op = alu_f3(f3, 1'b0);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) dec.alu_op = alu_f3(f3, 1'b1);
        else if (f7 == 7'h01 && ENABLE_M != 0)              dec.alu_op = ALU_MUL + {2'b0, f3};
        else                                                ill = 1'b1;
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        dec.csr_addr = in_instr[31:20];
        if (in_instr == 32'h3020_0073) dec.mret = 1'b1;
        else if (f3 == 3'd0 || f3 == 3'd4 || ENABLE_CSR == 0) ill = 1'b1;
        else begin
          // rs1 field carries zimm when csr_sel=1
          dec.rs1       = rs1;
          dec.rd        = rd;
          dec.rf_wen    = 1'b1;
          dec.csr_wen   = 1'b1;
          dec.wdata_sel = 2'd3;
          dec.csr_sel   = f3[2];
        end
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  dec_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rdy_q, rdy_d, push, pop;
  dec_t            head;

  assign push = in_valid && rdy_q && !flush;
  assign pop  = (cnt_q != '0) && out_ready && !flush;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
    rdy_d = (cnt_d < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      if (push) mem_q[wr_q] <= dec;
    end
  end

  assign head            = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign in_ready        = rdy_q;
  assign out_valid       = (cnt_q != '0);
  assign out_pc          = head.pc;
  assign out_rs1         = head.rs1;
  assign out_rs2         = head.rs2;
  assign out_rd          = head.rd;
  assign out_rf_wen      = head.rf_wen;
  assign out_dm_wen      = head.dm_wen;
  assign out_dm_ren      = head.dm_ren;
  assign out_mem_size    = head.mem_size;
  assign out_wdata_sel   = head.wdata_sel;
  assign out_op1_sel     = head.op1_sel;
  assign out_op2_sel     = head.op2_sel;
  assign out_alu_op      = head.alu_op;
  assign out_imm         = head.imm;
  assign out_branch      = head.branch;
  assign out_jal         = head.jal;
  assign out_jalr        = head.jalr;
  assign out_branch_cond = head.branch_cond;
  assign out_csr_wen     = head.csr_wen;
  assign out_csr_sel     = head.csr_sel;
  assign out_csr_addr    = head.csr_addr;
  assign out_mret        = head.mret;
  assign out_illegal     = head.illegal;

endmodule

// File: tb/tb_pipelined_decode_unit.sv
// Bench for pipelined_decode_unit: two instances (M off/CSR on, M on/CSR off)
// share stimulus and are checked against a queue-based decode model.
module tb_pipelined_decode_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        rf_wen, dm_wen, dm_ren;
    logic [2:0]  mem_size;
    logic [1:0]  wdata_sel, op1_sel;
    logic        op2_sel;
    logic [4:0]  alu_op;
    logic [31:0] imm;
    logic        branch, jal, jalr;
    logic [2:0]  branch_cond;
    logic        csr_wen, csr_sel;
    logic [11:0] csr_addr;
    logic        mret, illegal;
  } exp_t;

  localparam int DEPTH = 2;
  localparam logic [4:0] ALU_BASE [8] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9};
  localparam logic [6:0] OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23,
                                      7'h63, 7'h13, 7'h33, 7'h0F, 7'h73};
  localparam logic [6:0] F7S [3] = '{7'h00, 7'h20, 7'h01};

  logic gclk = 1'b0;
  logic grst_n, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [1:0]       o_valid, o_rdy, o_rf_wen, o_dm_wen, o_dm_ren, o_op2, o_br, o_jal, o_jalr;
  logic [1:0]       o_csr_wen, o_csr_sel, o_mret, o_ill;
  logic [1:0][31:0] o_pc, o_imm;
  logic [1:0][4:0]  o_rs1, o_rs2, o_rd, o_alu;
  logic [1:0][2:0]  o_msz, o_bcond;
  logic [1:0][1:0]  o_wsel, o_op1;
  logic [1:0][11:0] o_csra;

  int   n_chk = 0, n_err = 0;
  exp_t q0[$], q1[$];

  always #5 gclk = ~gclk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pipelined_decode_unit #(.XLEN(32), .DEPTH(DEPTH), .ENABLE_M(g), .ENABLE_CSR(1 - g)) u_dut (
      .clk(gclk), .rst_n(grst_n), .flush(flush), .in_valid(in_valid), .in_ready(o_rdy[g]),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(o_valid[g]), .out_ready(out_ready),
      .out_pc(o_pc[g]), .out_rs1(o_rs1[g]), .out_rs2(o_rs2[g]), .out_rd(o_rd[g]),
      .out_rf_wen(o_rf_wen[g]), .out_dm_wen(o_dm_wen[g]), .out_dm_ren(o_dm_ren[g]),
      .out_mem_size(o_msz[g]), .out_wdata_sel(o_wsel[g]), .out_op1_sel(o_op1[g]),
      .out_op2_sel(o_op2[g]), .out_alu_op(o_alu[g]), .out_imm(o_imm[g]),
      .out_branch(o_br[g]), .out_jal(o_jal[g]), .out_jalr(o_jalr[g]),
      .out_branch_cond(o_bcond[g]), .out_csr_wen(o_csr_wen[g]), .out_csr_sel(o_csr_sel[g]),
      .out_csr_addr(o_csra[g]), .out_mret(o_mret[g]), .out_illegal(o_ill[g]));
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decode reference: immediates via arithmetic shifts of the raw word.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                   input bit en_m, input bit en_csr);
    exp_t        e = '0;
    bit          bad = 0;
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3 = ins[14:12];
    logic [6:0]  f7 = ins[31:25];
    logic [31:0] i_imm = 32'($signed(ins) >>> 20);
    logic [31:0] s_imm = 32'($signed(ins & 32'hFE00_0000) >>> 20) | {27'd0, ins[11:7]};
    logic [31:0] b_imm = 32'($signed(ins & 32'h8000_0000) >>> 19) |
                         {20'd0, ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [31:0] j_imm = 32'($signed(ins & 32'h8000_0000) >>> 11) | (ins & 32'h000F_F000) |
                         {20'd0, ins[20], ins[30:21], 1'b0};
    logic [31:0] u_imm = ins & 32'hFFFF_F000;
    e.pc = pc;
    case (opc)
      7'h37: begin e.rd = ins[11:7]; e.rf_wen = 1; e.op1_sel = 2; e.op2_sel = 1; e.imm = u_imm; end
      7'h17: begin e.rd = ins[11:7]; e.rf_wen = 1; e.op1_sel = 1; e.op2_sel = 1; e.imm = u_imm; end
      7'h6F: begin
        e.rd = ins[11:7]; e.rf_wen = 1; e.wdata_sel = 2; e.jal = 1;
        e.op1_sel = 1; e.op2_sel = 1; e.imm = j_imm;
      end
      7'h67: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rf_wen = 1; e.wdata_sel = 2; e.jalr = 1;
        e.op2_sel = 1; e.imm = i_imm;
      end
      7'h03: begin
        bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rf_wen = 1; e.dm_ren = 1; e.wdata_sel = 1;
        e.op2_sel = 1; e.imm = i_imm; e.mem_size = f3;
      end
      7'h23: begin
        bad = f3 > 2;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.dm_wen = 1; e.op2_sel = 1;
        e.imm = s_imm; e.mem_size = f3;
      end
      7'h63: begin
        bad = (f3 == 2) || (f3 == 3);
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.branch = 1; e.branch_cond = f3;
        e.imm = b_imm; e.alu_op = (f3 < 2) ? 5'd1 : (f3 < 6) ? 5'd3 : 5'd4;
      end
      7'h13: begin
        e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rf_wen = 1; e.op2_sel = 1; e.imm = i_imm;
        e.alu_op = ALU_BASE[f3];
        if (f3 == 1) bad = (f7 != 0);
        if (f3 == 5) begin
          if (f7 == 7'h20) e.alu_op = 5'd7;
          else bad = (f7 != 0);
        end
      end
      7'h33: begin
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.rf_wen = 1;
        if (f7 == 0) e.alu_op = ALU_BASE[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu_op = 5'd1;
        else if (f7 == 7'h20 && f3 == 5) e.alu_op = 5'd7;
        else if (f7 == 7'h01 && en_m) e.alu_op = 5'(10 + f3);
        else bad = 1;
      end
      7'h0F: ;
      7'h73: begin
        e.csr_addr = ins[31:20];
        if (ins == 32'h3020_0073) e.mret = 1;
        else if (f3 == 0 || f3 == 4 || !en_csr) bad = 1;
        else begin
          e.rs1 = ins[19:15]; e.rd = ins[11:7]; e.rf_wen = 1; e.csr_wen = 1;
          e.wdata_sel = 3; e.csr_sel = f3[2];
        end
      end
      default: bad = 1;
    endcase
    if (bad) begin
      e = '0;
      e.pc = pc;
      e.illegal = 1;
    end
    return e;
  endfunction

  function automatic exp_t obs(input int k);
    exp_t o;
    o = '{o_pc[k], o_rs1[k], o_rs2[k], o_rd[k], o_rf_wen[k], o_dm_wen[k], o_dm_ren[k],
          o_msz[k], o_wsel[k], o_op1[k], o_op2[k], o_alu[k], o_imm[k], o_br[k], o_jal[k],
          o_jalr[k], o_bcond[k], o_csr_wen[k], o_csr_sel[k], o_csra[k], o_mret[k], o_ill[k]};
    return o;
  endfunction

  task automatic check_all();
    exp_t h0 = (q0.size() > 0) ? q0[0] : '0;
    exp_t h1 = (q1.size() > 0) ? q1[0] : '0;
    chk("valid0", o_valid[0], q0.size() > 0);
    chk("ready0", o_rdy[0], q0.size() < DEPTH);
    chk("bundle0", obs(0), h0);
    chk("valid1", o_valid[1], q1.size() > 0);
    chk("ready1", o_rdy[1], q1.size() < DEPTH);
    chk("bundle1", obs(1), h1);
  endtask

  // Check current state, drive one cycle of inputs, advance the model.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl);
    bit can_push, do_pop;
    check_all();
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    can_push = v && (q0.size() < DEPTH);
    do_pop   = ordy && (q0.size() > 0);
    @(posedge gclk);
    if (fl) begin
      q0.delete(); q1.delete();
    end else begin
      if (do_pop) begin void'(q0.pop_front()); void'(q1.pop_front()); end
      if (can_push) begin
        q0.push_back(ref_dec(ins, pc, 1'b0, 1'b1));
        q1.push_back(ref_dec(ins, pc, 1'b1, 1'b0));
      end
    end
    @(negedge gclk);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    int sel = $urandom_range(0, 3);
    case ($urandom_range(0, 15))
      0: return 32'h3020_0073;
      1: return r;
      default: begin
        r[6:0] = OPS[$urandom_range(0, 10)];
        if (sel < 3) r[31:25] = F7S[sel];
        return r;
      end
    endcase
  endfunction

  initial begin
    grst_n = 0; flush = 0; in_valid = 0; out_ready = 0; in_instr = '0; in_pc = '0;
    repeat (2) @(negedge gclk);
    check_all();
    chk("rst_ready", o_rdy[0], 1'b1);
    grst_n = 1;

    // sub x2,x1,x2
    cyc(1, 32'h4020_8133, 32'h100, 1, 0);
    chk("sub_alu", o_alu[0], 5'd1);
    chk("sub_regs", {o_rs1[0], o_rs2[0], o_rd[0]}, {5'd1, 5'd2, 5'd2});
    chk("sub_wen_op2", {o_rf_wen[0], o_op2[0]}, 2'b10);
    chk("sub_pc", o_pc[0], 32'h100);
    // mul x3,x1,x2
    cyc(1, 32'h0220_81B3, 32'h104, 1, 0);
    chk("mul_ill_m0", {o_ill[0], o_rf_wen[0]}, 2'b10);
    chk("mul_alu_m1", {o_ill[1], o_rf_wen[1], o_alu[1]}, {2'b01, 5'd10});
    // lui x1,0xFFFFF
    cyc(1, 32'hFFFF_F0B7, 32'h108, 1, 0);
    chk("lui_imm", o_imm[0], 32'hFFFF_F000);
    chk("lui_op1", o_op1[0], 2'd2);
    cyc(1, 32'h3020_0073, 32'h10C, 1, 0);
    chk("mret", {o_mret[0], o_csr_wen[0], o_mret[1], o_ill[1]}, 4'b1010);
    // beq x0,x0,-4
    cyc(1, 32'hFE00_0EE3, 32'h110, 1, 0);
    chk("beq_br", o_br[0], 1'b1);
    chk("beq_imm", o_imm[0], 32'hFFFF_FFFC);
    // csrrw x5,mstatus,x6 on the CSR-disabled instance is illegal
    cyc(1, 32'h3003_12F3, 32'h114, 1, 0);
    chk("csrrw", {o_csr_wen[0], o_wsel[0], o_ill[1]}, 4'b1111);
    cyc(0, '0, '0, 1, 0);

    // fill with execute stalled; third push must wait
    cyc(1, 32'h0010_0093, 32'h200, 0, 0);
    cyc(1, 32'h0020_0113, 32'h204, 0, 0);
    cyc(1, 32'h0030_0193, 32'h208, 0, 0);
    chk("full_ready", o_rdy[0], 1'b0);
    chk("full_head_pc", o_pc[0], 32'h200);
    cyc(1, 32'h0030_0193, 32'h208, 1, 0);
    cyc(1, 32'h0030_0193, 32'h208, 1, 0);
    repeat (3) cyc(0, '0, '0, 1, 0);

    // flush with a full buffer and a valid input
    cyc(1, 32'h0000_0013, 32'h300, 0, 0);
    cyc(1, 32'h0000_0013, 32'h304, 0, 0);
    cyc(1, 32'h0000_0013, 32'h308, 0, 1);
    chk("flush_valid", o_valid[0], 1'b0);
    chk("flush_ready", o_rdy[0], 1'b1);
    cyc(0, '0, '0, 0, 0);

    // asynchronous reset mid-stream with two entries held
    cyc(1, 32'h0050_0293, 32'h400, 0, 0);
    cyc(1, 32'h0060_0313, 32'h404, 0, 0);
    check_all();
    in_valid = 0;
    #1 grst_n = 0;
    @(negedge gclk);
    q0.delete(); q1.delete();
    chk("arst_valid", o_valid[0], 1'b0);
    chk("arst_ready", o_rdy[0], 1'b1);
    check_all();
    grst_n = 1;

    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 7, rnd_instr(), {$urandom} & 32'hFFFF_FFFC,
          $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    repeat (3) cyc(0, '0, '0, 1, 0);
    check_all();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
